// File: rtl/calc_input_ctrl.sv
// Button front-end for the calculator: sync, debounce and press-pulse per
// button, plus the opcode sequencer and mode flag those presses drive.

module calc_input_ctrl_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Accept the new level; only a rising acceptance is a press.
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module calc_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       opcode_btn_i,
    input  logic       mode_btn_i,
    output logic [3:0] opcode_o,
    output logic       mode_flag_o,
    output logic       opcode_step_o,
    output logic       mode_toggle_o
);

    calc_input_ctrl_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_opcode_chan (
        .clk  (clk_i),
        .rst  (rst_i),
        .raw  (opcode_btn_i),
        .press(opcode_step_o)
    );

    calc_input_ctrl_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_mode_chan (
        .clk  (clk_i),
        .rst  (rst_i),
        .raw  (mode_btn_i),
        .press(mode_toggle_o)
    );

    // ALU opcode order; unreachable codes fall back to 0.
    function automatic logic [3:0] next_opcode(input logic [3:0] cur);
        logic [3:0] nxt;
        case (cur)
            4'd0:    nxt = 4'd1;
            4'd1:    nxt = 4'd2;
            4'd2:    nxt = 4'd3;
            4'd3:    nxt = 4'd4;
            4'd4:    nxt = 4'd5;
            4'd5:    nxt = 4'd6;
            4'd6:    nxt = 4'd7;
            4'd7:    nxt = 4'd9;
            4'd9:    nxt = 4'd14;
            4'd14:   nxt = 4'd0;
            default: nxt = 4'd0;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opcode_o    <= 4'd6;
            mode_flag_o <= 1'b1;
        end else begin
            if (opcode_step_o) begin
                opcode_o <= next_opcode(opcode_o);
            end
            if (mode_toggle_o) begin
                mode_flag_o <= ~mode_flag_o;
            end
        end
    end

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Directed and randomised checks of calc_input_ctrl against a
// sample-history reference model, with DEBOUNCE_CYCLES = 4.

module tb_calc_input_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ob  = 1'b0;
    logic       mb  = 1'b0;
    logic [3:0] opcode;
    logic       mode_flag;
    logic       step_p;
    logic       tog_p;

    calc_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_btn_i (ob),
        .mode_btn_i   (mb),
        .opcode_o     (opcode),
        .mode_flag_o  (mode_flag),
        .opcode_step_o(step_p),
        .mode_toggle_o(tog_p)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    int seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 14};
    int exp3[10] = '{7, 9, 14, 0, 1, 2, 3, 4, 5, 6};

    int idx;
    bit m_mode, m_step, m_tog;
    bit qo[$];
    bit qm[$];
    bit st_o, st_m;
    int run_o, run_m;

    function automatic void model_reset();
        idx    = 6;
        m_mode = 1'b1;
        m_step = 1'b0;
        m_tog  = 1'b0;
        qo.delete();
        qm.delete();
        st_o  = 1'b0;
        st_m  = 1'b0;
        run_o = 0;
        run_m = 0;
    endfunction

    // A level is accepted once it has differed from the accepted level
    // for D consecutive synchronised samples.
    function automatic void deb(input bit s, inout bit st, inout int run,
                                output bit p);
        p = 1'b0;
        if (s != st) begin
            run++;
            if (run == D) begin
                st  = s;
                run = 0;
                p   = s;
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".opcode"}, opcode, 4'(seq[idx]));
        check({tag, ".mode"}, {3'b0, mode_flag}, {3'b0, m_mode});
        check({tag, ".step"}, {3'b0, step_p}, {3'b0, m_step});
        check({tag, ".toggle"}, {3'b0, tog_p}, {3'b0, m_tog});
    endtask

    // One clock edge: advance the model, then compare on the falling edge.
    task automatic step(input string tag);
        bit so, sm;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_step) idx = (idx + 1) % 10;
            if (m_tog) m_mode = !m_mode;
            so = (qo.size() >= 2) ? qo[qo.size()-2] : 1'b0;
            sm = (qm.size() >= 2) ? qm[qm.size()-2] : 1'b0;
            qo.push_back(ob);
            qm.push_back(mb);
            deb(so, st_o, run_o, m_step);
            deb(sm, st_m, run_m, m_tog);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Assert reset between edges and check it takes effect immediately.
    task automatic do_reset(input int hold);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        steps("rst_hold", hold);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        steps("por", 2);
        rst = 1'b0;

        // Press and hold, then release
        do_reset(2);
        ob = 1'b1;
        steps("hold", 20);
        check("hold.op7", opcode, 4'd7);
        ob = 1'b0;
        steps("release", 20);
        check("release.op7", opcode, 4'd7);

        // Ten clean presses walk the whole sequence
        do_reset(1);
        for (int p = 0; p < 10; p++) begin
            ob = 1'b1;
            steps("seq_hi", 8);
            check("seq.op", opcode, 4'(exp3[p]));
            ob = 1'b0;
            steps("seq_lo", 8);
        end

        // Short glitches are rejected
        do_reset(1);
        for (int g = 0; g < 5; g++) begin
            ob = 1'b1;
            steps("glitch_hi", 3);
            ob = 1'b0;
            steps("glitch_lo", 3);
        end
        check("glitch.op6", opcode, 4'd6);

        // Both buttons on the same edge
        do_reset(1);
        ob = 1'b1;
        mb = 1'b1;
        steps("both", 8);
        check("both.op7", opcode, 4'd7);
        check("both.mode0", {3'b0, mode_flag}, 4'd0);
        ob = 1'b0;
        mb = 1'b0;
        steps("both_rel", 8);

        // Reset mid-debounce with the button still held
        do_reset(1);
        ob = 1'b1;
        steps("mid", 4);
        do_reset(2);
        steps("redeb", 10);
        check("redeb.op7", opcode, 4'd7);
        ob = 1'b0;
        steps("redeb_rel", 8);

        // Random hold lengths on both buttons
        for (int r = 0; r < 300; r++) begin
            ob = 1'($urandom_range(0, 1));
            mb = 1'($urandom_range(0, 1));
            steps("rand", int'($urandom_range(1, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
